parallel_bus_slave_burst: RTL and testbench

Parametrised slave for the 8-bit-class parallel bus (enable / read / register_select strobes driven by an external master, e.g. a Raspberry Pi GPIO port). It assembles multi-transaction addresses and multi-transaction data words, and drives a synchronous-read RAM port. It also auto-increments the address for burst access, counts protocol errors, and returns ack_valid per transaction. It replaces single-byte-address slaves in top-level builds and sits between the bus pins (through a tristate bus entry) and an inferred RAM.

---
 rtl/parallel_bus_slave_burst_pkg.sv | 11 +
 rtl/parallel_bus_synchronizer.sv | 18 +
 rtl/parallel_bus_slave_burst.sv | 181 ++++++++++++++++++
 tb/tb_parallel_bus_slave_burst.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_bus_slave_burst_pkg.sv
// Shared types for the burst parallel-bus slave: FSM states, the kind of
// transaction held between CAPTURE and RELEASE, and the error counter width.
package parallel_bus_slave_burst_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, RELEASE} state_t;

  typedef enum logic [1:0] {K_NONE, K_ADDR, K_WRITE, K_READ} kind_t;

  localparam int ERR_W = 32;

endpackage

// File: rtl/parallel_bus_synchronizer.sv
// Two-flop synchronizer for the asynchronous bus pins. The flops carry no
// reset, so a pin held high through reset is still seen high afterwards.
module parallel_bus_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    meta   <= pins;
    synced <= meta;
  end

endmodule

// File: rtl/parallel_bus_slave_burst.sv
// Parallel-bus slave: assembles multi-slice addresses and words from the bus,
// drives a synchronous-read RAM port, auto-increments and counts protocol errors.
module parallel_bus_slave_burst
  import parallel_bus_slave_burst_pkg::*;
#(
  parameter int WIDTH                    = 8,
  parameter int TRANSACTIONS_PER_WORD    = 4,
  parameter int TRANSACTIONS_PER_ADDRESS = 2,
  parameter int AUTOINCREMENT            = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [WIDTH-1:0]                      bus_in,
  output logic [WIDTH-1:0]                      bus_out,
  output logic                                  bus_oe,
  input  logic                                  read,
  input  logic                                  register_select,
  input  logic                                  enable,
  output logic                                  ack_valid,
  output logic [WIDTH*TRANSACTIONS_PER_ADDRESS-1:0] address,
  output logic [WIDTH*TRANSACTIONS_PER_WORD-1:0]    write_data_word,
  output logic                                  write_strobe,
  input  logic [WIDTH*TRANSACTIONS_PER_WORD-1:0]    read_data_word,
  output logic [ERR_W-1:0]                      errors
);

  localparam int AW  = WIDTH * TRANSACTIONS_PER_ADDRESS;
  localparam int DW  = WIDTH * TRANSACTIONS_PER_WORD;
  localparam int ACW = (TRANSACTIONS_PER_ADDRESS > 1) ? $clog2(TRANSACTIONS_PER_ADDRESS) : 1;
  localparam int WCW = (TRANSACTIONS_PER_WORD > 1) ? $clog2(TRANSACTIONS_PER_WORD) : 1;
  localparam logic [ACW-1:0] A_MAX = ACW'(TRANSACTIONS_PER_ADDRESS - 1);
  localparam logic [WCW-1:0] W_MAX = WCW'(TRANSACTIONS_PER_WORD - 1);

  logic [WIDTH+2:0] sync_vec;
  logic [WIDTH-1:0] bus_s;
  logic             rd_s, rs_s, en_s, en_prev;
  logic             enable_rise, enable_fall;

  parallel_bus_synchronizer #(.WIDTH(WIDTH + 3)) u_sync (
    .clock  (clock),
    .pins   ({bus_in, read, register_select, enable}),
    .synced (sync_vec)
  );

  assign bus_s = sync_vec[WIDTH+2:3];
  assign rd_s  = sync_vec[2];
  assign rs_s  = sync_vec[1];
  assign en_s  = sync_vec[0];

  always_ff @(posedge clock) begin
    if (reset) en_prev <= 1'b1;
    else       en_prev <= en_s;
  end

  assign enable_rise = en_s & ~en_prev;
  assign enable_fall = ~en_s & en_prev;

  state_t          state, state_next;
  kind_t           kind;
  logic [ACW-1:0]  aword;
  logic [WCW-1:0]  wword, rword, w_idx, r_idx;
  logic [AW-1:0]   addr_asm;
  logic [DW-1:0]   shadow;
  logic            inc_pending, err_hit;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // CAPTURE re-checks enable so a pulse too short to survive two samples is dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_rise) state_next = CAPTURE;
      CAPTURE: state_next = en_s ? ACK : IDLE;
      ACK:     if (enable_fall) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A direction change restarts the word at its most significant slice.
  assign w_idx = (rword != W_MAX) ? W_MAX : wword;
  assign r_idx = (wword != W_MAX) ? W_MAX : rword;

  always_comb begin
    err_hit = 1'b0;
    if (state == CAPTURE && en_s) begin
      if (!rs_s)               err_hit = rd_s || (wword != W_MAX) || (rword != W_MAX);
      else if (aword != A_MAX) err_hit = 1'b1;
      else if (rd_s)           err_hit = (wword != W_MAX);
      else                     err_hit = (rword != W_MAX);
    end
  end

  assign bus_oe = (state == CAPTURE && en_s && rd_s && rs_s && aword == A_MAX) ||
                  ((state == ACK || state == RELEASE) && kind == K_READ);

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_valid       <= 1'b0;
      write_strobe    <= 1'b0;
      errors          <= '0;
      address         <= '0;
      write_data_word <= '0;
      bus_out         <= '0;
      aword           <= A_MAX;
      wword           <= W_MAX;
      rword           <= W_MAX;
      addr_asm        <= '0;
      shadow          <= '0;
      kind            <= K_NONE;
      inc_pending     <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      if (err_hit && errors != '1) errors <= errors + ERR_W'(1);
      if (inc_pending) begin
        address     <= address + AW'(1);
        inc_pending <= 1'b0;
      end
      case (state)
        CAPTURE: if (en_s) begin
          ack_valid <= 1'b1;
          kind      <= K_NONE;
          if (!rs_s) begin
            if (!rd_s) begin
              wword <= W_MAX;
              rword <= W_MAX;
              addr_asm[aword*WIDTH +: WIDTH] <= bus_s;
              kind  <= K_ADDR;
            end
          end else if (aword != A_MAX) begin
            aword <= A_MAX;
          end else if (rd_s) begin
            wword <= W_MAX;
            rword <= r_idx;
            kind  <= K_READ;
            if (r_idx == W_MAX) begin
              shadow  <= read_data_word;
              bus_out <= read_data_word[W_MAX*WIDTH +: WIDTH];
            end else begin
              bus_out <= shadow[r_idx*WIDTH +: WIDTH];
            end
          end else begin
            rword <= W_MAX;
            wword <= w_idx;
            write_data_word[w_idx*WIDTH +: WIDTH] <= bus_s;
            kind  <= K_WRITE;
          end
        end
        RELEASE: begin
          ack_valid <= 1'b0;
          case (kind)
            K_ADDR:
              if (aword == '0) begin
                address <= addr_asm;
                aword   <= A_MAX;
                wword   <= W_MAX;
                rword   <= W_MAX;
              end else aword <= aword - ACW'(1);
            K_WRITE:
              if (wword == '0) begin
                write_strobe <= 1'b1;
                wword        <= W_MAX;
                inc_pending  <= (AUTOINCREMENT != 0);
              end else wword <= wword - WCW'(1);
            K_READ:
              if (rword == '0) begin
                rword <= W_MAX;
                if (AUTOINCREMENT != 0) address <= address + AW'(1);
              end else rword <= rword - WCW'(1);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_bus_slave_burst.sv
// Bench for parallel_bus_slave_burst: directed vector table, random traffic
// against a transaction-level model, and reset / glitch corner cases.
module tb_parallel_bus_slave_burst;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  bus_in = '0;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        read = 1'b0;
  logic        register_select = 1'b0;
  logic        enable = 1'b0;
  logic        ack_valid;
  logic [15:0] address;
  logic [31:0] write_data_word;
  logic        write_strobe;
  logic [31:0] read_data_word;
  logic [31:0] errors;

  parallel_bus_slave_burst #(
    .WIDTH(8), .TRANSACTIONS_PER_WORD(4), .TRANSACTIONS_PER_ADDRESS(2), .AUTOINCREMENT(1)
  ) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .read(read), .register_select(register_select), .enable(enable), .ack_valid(ack_valid),
    .address(address), .write_data_word(write_data_word), .write_strobe(write_strobe),
    .read_data_word(read_data_word), .errors(errors)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM attached to the slave.
  logic [31:0] ram [0:65535];
  initial for (int i = 0; i < 65536; i++) ram[i] <= '0;
  always @(posedge clock) begin
    if (write_strobe) ram[address] <= write_data_word;
    read_data_word <= ram[address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_strobes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Transaction-level reference model.
  int          m_apart, m_wcnt, m_rcnt, m_err;
  logic [15:0] m_abuf, m_addr;
  logic [31:0] m_wbuf, m_shadow;
  logic [31:0] m_mem [0:65535];
  logic [47:0] exp_wr[$];

  task automatic model_reset();
    m_apart = 0; m_wcnt = 0; m_rcnt = 0; m_err = 0; m_addr = '0; m_abuf = '0; m_wbuf = '0;
    exp_wr.delete();
  endtask

  task automatic model_txn(input bit rs, input bit rd, input logic [7:0] d,
                           output logic [7:0] eo, output bit eoe);
    eo = '0; eoe = 1'b0;
    if (!rs) begin
      if (rd) m_err++;
      else begin
        if (m_wcnt != 0 || m_rcnt != 0) begin m_err++; m_wcnt = 0; m_rcnt = 0; end
        m_abuf = {m_abuf[7:0], d};
        m_apart++;
        if (m_apart == 2) begin m_addr = m_abuf; m_apart = 0; end
      end
    end else if (m_apart != 0) begin
      m_err++; m_apart = 0;
    end else if (rd) begin
      if (m_wcnt != 0) begin m_err++; m_wcnt = 0; end
      if (m_rcnt == 0) m_shadow = m_mem[m_addr];
      eo = m_shadow[31 - 8*m_rcnt -: 8];
      eoe = 1'b1;
      m_rcnt++;
      if (m_rcnt == 4) begin m_rcnt = 0; m_addr++; end
    end else begin
      if (m_rcnt != 0) begin m_err++; m_rcnt = 0; end
      m_wbuf = {m_wbuf[23:0], d};
      m_wcnt++;
      if (m_wcnt == 4) begin
        exp_wr.push_back({m_addr, m_wbuf});
        m_mem[m_addr] = m_wbuf;
        m_addr++;
        m_wcnt = 0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (write_strobe) begin
      logic [47:0] e;
      n_strobes++;
      if (exp_wr.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL write_unexpected: got addr %h data %h, required no write", address, write_data_word);
      end else begin
        e = exp_wr.pop_front();
        check("write_addr_data", {address, write_data_word}, e);
      end
    end
  end

  task automatic do_txn(input bit rs, input bit rd, input logic [7:0] d,
                        output logic [7:0] got, output bit got_oe);
    int k;
    @(negedge clock);
    register_select = rs; read = rd; bus_in = d;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!ack_valid && k < 20);
    check("ack_rise", ack_valid, 1);
    check("ack_latency", k, 4);
    got = bus_out; got_oe = bus_oe;
    enable = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (ack_valid && k < 20);
    check("ack_fall", ack_valid, 0);
    check("ack_drop_latency", k, 4);
    repeat (4) @(negedge clock);
  endtask

  task automatic model_step(input bit rs, input bit rd, input logic [7:0] d);
    logic [7:0] eo, got; bit eoe, goe;
    model_txn(rs, rd, d, eo, eoe);
    do_txn(rs, rd, d, got, goe);
    check("model_addr", address, m_addr);
    check("model_errors", errors, m_err);
    check("model_oe", goe, eoe);
    if (eoe) check("model_rdata", got, eo);
  endtask

  typedef struct {
    bit rs; bit rd; logic [7:0] d;
    bit chk; logic [7:0] out; logic [15:0] addr; int err; int strobes;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rs, bit rd, logic [7:0] d, bit chk, logic [7:0] out,
                              logic [15:0] addr, int err, int strobes);
    vec_t v;
    v.rs = rs; v.rd = rd; v.d = d; v.chk = chk; v.out = out;
    v.addr = addr; v.err = err; v.strobes = strobes;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] eo, got; bit eoe, goe; bit saw; int sb; int k;
    for (int i = 0; i < 65536; i++) m_mem[i] = '0;
    model_reset();

    add(0,0,8'hab,0,0,16'h0000,0,0); add(0,0,8'h4c,0,0,16'hab4c,0,0);
    add(1,0,8'h31,0,0,16'hab4c,0,0); add(1,0,8'h23,0,0,16'hab4c,0,0);
    add(1,0,8'h2a,0,0,16'hab4c,0,0); add(1,0,8'h12,0,0,16'hab4d,0,1);
    add(0,0,8'hab,0,0,16'hab4d,0,1); add(0,0,8'h4c,0,0,16'hab4c,0,1);
    add(1,1,8'h00,1,8'h31,16'hab4c,0,1); add(1,1,8'h00,1,8'h23,16'hab4c,0,1);
    add(1,1,8'h00,1,8'h2a,16'hab4c,0,1); add(1,1,8'h00,1,8'h12,16'hab4d,0,1);
    add(0,0,8'h00,0,0,16'hab4d,0,1); add(1,0,8'h55,0,0,16'hab4d,1,1);
    add(0,0,8'hab,0,0,16'hab4d,1,1); add(0,0,8'h4c,0,0,16'hab4c,1,1);
    add(1,0,8'h77,0,0,16'hab4c,1,1); add(1,0,8'h66,0,0,16'hab4c,1,1);
    add(1,1,8'h00,1,8'h31,16'hab4c,2,1); add(1,1,8'h00,1,8'h23,16'hab4c,2,1);
    add(1,1,8'h00,1,8'h2a,16'hab4c,2,1); add(1,1,8'h00,1,8'h12,16'hab4d,2,1);
    add(0,0,8'h00,0,0,16'hab4d,2,1); add(0,0,8'hfe,0,0,16'h00fe,2,1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        add(1,0,8'((j+1)*16 + i),0,0, (j < 3) ? 16'(16'h00fe + i) : 16'(16'h00ff + i), 2,
            (j < 3) ? 1 + i : 2 + i);
    add(0,0,8'hff,0,0,16'h0102,2,5); add(0,0,8'hff,0,0,16'hffff,2,5);
    add(1,0,8'hde,0,0,16'hffff,2,5); add(1,0,8'had,0,0,16'hffff,2,5);
    add(1,0,8'hbe,0,0,16'hffff,2,5); add(1,0,8'hef,0,0,16'h0000,2,6);

    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ack", ack_valid, 0);
    check("rst_strobe", write_strobe, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_errors", errors, 0);
    check("rst_address", address, 0);
    check("rst_wdata", write_data_word, 0);
    check("rst_bus_out", bus_out, 0);

    foreach (tbl[i]) begin
      model_txn(tbl[i].rs, tbl[i].rd, tbl[i].d, eo, eoe);
      do_txn(tbl[i].rs, tbl[i].rd, tbl[i].d, got, goe);
      check("vec_address", address, tbl[i].addr);
      check("vec_errors", errors, tbl[i].err);
      check("vec_strobes", n_strobes, tbl[i].strobes);
      check("vec_oe", goe, tbl[i].chk);
      if (tbl[i].chk) check("vec_rdata", got, tbl[i].out);
    end
    check("ram_ab4c", ram[16'hab4c], 32'h31232a12);
    check("ram_00fe", ram[16'h00fe], 32'h10203040);
    check("ram_00ff", ram[16'h00ff], 32'h11213141);
    check("ram_0100", ram[16'h0100], 32'h12223242);
    check("ram_0101", ram[16'h0101], 32'h13233343);
    check("ram_ffff", ram[16'hffff], 32'hdeadbeef);

    // One-clock enable glitch between two address slices must be ignored.
    model_step(0, 0, 8'h12);
    @(negedge clock);
    register_select = 1'b0; read = 1'b0; bus_in = 8'h99;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    saw = 1'b0;
    repeat (12) begin @(negedge clock); if (ack_valid) saw = 1'b1; end
    check("glitch_no_ack", saw, 0);
    model_step(0, 0, 8'h34);
    check("glitch_address", address, 16'h1234);

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      model_step(0, 0, 8'($urandom_range(0, 3)));
      else if (k < 6) model_step(1, 0, 8'($urandom));
      else if (k < 9) model_step(1, 1, 8'($urandom));
      else            model_step(0, 1, 8'($urandom));
    end

    // Reset during the ACK of the third write slice, enable held high.
    model_step(0, 0, 8'h12); model_step(0, 0, 8'h34);
    model_step(1, 0, 8'haa); model_step(1, 0, 8'hbb);
    @(negedge clock);
    register_select = 1'b1; read = 1'b0; bus_in = 8'hcc;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!ack_valid && k < 20);
    check("pre_reset_ack", ack_valid, 1);
    sb = n_strobes;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("mid_rst_ack", ack_valid, 0);
    check("mid_rst_oe", bus_oe, 0);
    check("mid_rst_errors", errors, 0);
    check("mid_rst_address", address, 0);
    check("mid_rst_wdata", write_data_word, 0);
    check("mid_rst_bus_out", bus_out, 0);
    saw = 1'b0;
    repeat (10) begin @(negedge clock); if (ack_valid || write_strobe) saw = 1'b1; end
    check("held_enable_no_ack", saw, 0);
    check("mid_rst_no_strobe", n_strobes, sb);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    model_step(0, 0, 8'h56);
    check("post_rst_partial_addr", address, 16'h0000);
    model_step(0, 0, 8'h78);
    check("post_rst_address", address, 16'h5678);
    model_step(1, 0, 8'h01); model_step(1, 0, 8'h02);
    model_step(1, 0, 8'h03); model_step(1, 0, 8'h04);
    check("post_rst_strobes", n_strobes, sb + 1);
    check("post_rst_ram", ram[16'h5678], 32'h01020304);
    check("write_queue_drained", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
